zap_tlb_walker: RTL and testbench
=================================

Name: zap_tlb_walker

Overview:
- Page-table walker that services the walk request raised by the TLB check logic on a TLB miss.
- Fetches first-level and second-level descriptors over a Wishbone read-only master port, decodes them, and emits one TLB refill write (section, small, large or fine page TLB) or one fault report (FSR/FAR).
- Sits inside the MMU between the TLB check/RAM block and the memory arbiter.

Parameters:
- LPAGE_TLB_ENTRIES, 8, large page TLB depth; passed through so the shared width macros resolve.
- SPAGE_TLB_ENTRIES, 8, small page TLB depth.
- SECTION_TLB_ENTRIES, 8, section TLB depth.
- FPAGE_TLB_ENTRIES, 8, fine page TLB depth.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset  in  1  asynchronous active-high reset.
- i_walk  in  1  walk request from the TLB check; sampled only in IDLE.
- i_va  in  32  virtual address; latched with i_walk.
- i_baddr  in  32  translation table base; bits [31:14] used.
- o_busy  out  1  high whenever state != IDLE.
- o_wb_cyc, o_wb_stb  out  1  Wishbone cycle/strobe.
- o_wb_adr  out  32  descriptor address; [1:0]=0.
- o_wb_sel  out  4  constant 4'hF while cyc is high, else 0.
- o_wb_we  out  1  constant 0.
- i_wb_dat  in  32  read data.
- i_wb_ack  in  1  acknowledge.
- i_wb_err  in  1  bus error.
- o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen  out  1  one-cycle refill strobes.
- o_setlb_wdata, o_sptlb_wdata, o_lptlb_wdata, o_fptlb_wdata  out  `ZAP_*_TLB_WDT  entry data.
- o_fault  out  1  one-cycle fault pulse.
- o_fsr  out  8  {domain[3:0], status[3:0]}; valid with o_fault.
- o_far  out  32  faulting VA; valid with o_fault.

Behaviour:
- All outputs are registered. Reset value 0 for all outputs; state goes to IDLE.
- Reset mid-walk drops o_wb_cyc/o_wb_stb immediately; no wen or fault pulse is issued.
- States: IDLE, FETCH_L1, DECODE_L1, FETCH_L2, DECODE_L2, REFILL, FAULT, SETTLE.
- IDLE:
  - i_walk=1 at edge k: latch i_va into va_q.
  - Drive cyc/stb=1 from cycle k+1, with o_wb_adr = {i_baddr[31:14], i_va[31:20], 2'b00}.
  - Go to FETCH_L1.
- FETCH_L1 / FETCH_L2:
  - cyc/stb/adr are held stable until ack or err.
  - On the ack edge: capture i_wb_dat, drop cyc/stb next cycle, go to DECODE_*.
  - ack and err asserted together: err wins.
  - err: go to FAULT with status 4'b1100 (L1) or 4'b1110 (L2). Domain = 0 for L1; domain = latched L1 domain for L2.
- DECODE_L1, on desc[1:0]:
  - 00: FAULT, FSR {4'd0, 4'b0101}.
  - 10 section: REFILL into section TLB.
  - 01 coarse: latch domain = desc[8:5]; FETCH_L2 with adr {desc[31:10], va_q[19:12], 2'b00}.
  - 11 fine: latch domain = desc[8:5]; FETCH_L2 with adr {desc[31:12], va_q[19:10], 2'b00}; remember fine=1.
- DECODE_L2, on desc[1:0]:
  - 00: FAULT, {domain, 4'b0111}.
  - 01: large page.
  - 10: small page.
  - 11: fine page if fine=1; if fine=0 (coarse table), FAULT {domain, 4'b0111}.
- Refill field packing. Fields use the shared `ZAP_*_TLB__ field macros; TAG = va_q[`ZAP_VA__*_TAG].
  - Section: BASE=desc[31:20], AP=desc[11:10], DAC_SEL=desc[8:5], CB=desc[3:2].
  - Small: BASE=desc[31:12], AP=desc[11:4].
  - Large: BASE=desc[31:16], AP=desc[11:4].
  - Fine: BASE=desc[31:10], AP=desc[5:4].
  - Page entries (small, large, fine): DAC_SEL = latched L1 domain; CB=desc[3:2].
  - Unused bits are 0.
- REFILL: exactly one wen high for one cycle, with wdata valid in the same cycle. Then SETTLE.
- FAULT: o_fault=1 for one cycle; o_far=va_q. No TLB write. Then SETTLE.
- SETTLE: one cycle; i_walk is ignored so the TLB read data can update. Then IDLE.
- Minimum latency, i_walk to wen, with zero-wait ack:
  - Section: 4 cycles.
  - Page: 6 cycles.
- i_va changes during a walk are ignored.

Decomposition:
- Shared package/defines:
  - FSR status codes: translation section/page, external abort L1/L2.
  - Descriptor type encodings.
  - TLB field macros and widths (already shared).
  - State enum typedef.
- Sub-module: zap_tlb_entry_pack (combinational descriptor+VA -> four TLB entry formats). Keeps the FSM separate from the field packing.

Test Plan:
- Section hit path: i_baddr=32'h0000_4000, i_va=32'h1230_0ABC, L1 read at 32'h0000_448C returns 32'h8000_0C1E.
  - Expect setlb_wen one pulse: BASE=12'h800, AP=2'b11, DAC_SEL=0, CB=2'b11.
  - Expect 4 cycles from i_walk with zero-wait ack.
- Coarse -> small: L1 desc 32'h0010_0021, i_va=32'h0000_5123.
  - Expect L2 read at 32'h0010_0014.
  - L2 desc 32'h9000_0FFE gives sptlb_wen: BASE=20'h90000, AP=8'hFF, DAC_SEL=1, CB=2'b11.
- L1 fault: L1 desc 32'h0.
  - Expect o_fault pulse with o_fsr=8'h05, o_far=i_va, no wen.
- Coarse table with L2 type 11: expect o_fsr={domain,4'h7}.
- Fine table with L2 type 11: expect fptlb_wen with BASE=desc[31:10].
- Bus error, and reset mid-walk:
  - Bus error on the L2 fetch with domain 3: expect o_fsr=8'h3E.
  - Separately, assert i_reset during FETCH_L2 while waiting for ack: cyc drops asynchronously and the block returns to IDLE with no strobes.

Source files
------------

// File: rtl/zap_tlb_walker_pkg.sv
// ---------------------------------------------------------------------------
// zap_tlb_walker_pkg
//
// Shared definitions for the MMU page-table walker:
//   - walker FSM state encoding
//   - first/second-level descriptor type encodings
//   - fault status (FSR) codes reported by the walker
//   - TLB entry layouts (packed structs) and their widths
//   - descriptor address helpers
// ---------------------------------------------------------------------------
package zap_tlb_walker_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_L1  = 3'd1,
    S_DECODE_L1 = 3'd2,
    S_FETCH_L2  = 3'd3,
    S_DECODE_L2 = 3'd4,
    S_REFILL    = 3'd5,
    S_FAULT     = 3'd6,
    S_SETTLE    = 3'd7
  } walk_state_t;

  // Which TLB a refill is destined for.
  typedef enum logic [1:0] {
    RK_SECTION = 2'd0,
    RK_SMALL   = 2'd1,
    RK_LARGE   = 2'd2,
    RK_FINE    = 2'd3
  } refill_kind_t;

  // Fault status codes.
  localparam logic [3:0] FSR_TRANS_SECTION = 4'b0101;
  localparam logic [3:0] FSR_TRANS_PAGE    = 4'b0111;
  localparam logic [3:0] FSR_EXT_ABORT_L1  = 4'b1100;
  localparam logic [3:0] FSR_EXT_ABORT_L2  = 4'b1110;

  // First-level descriptor types, desc[1:0].
  localparam logic [1:0] L1_FAULT   = 2'b00;
  localparam logic [1:0] L1_COARSE  = 2'b01;
  localparam logic [1:0] L1_SECTION = 2'b10;
  localparam logic [1:0] L1_FINE    = 2'b11;

  // Second-level descriptor types, desc[1:0].
  localparam logic [1:0] L2_FAULT = 2'b00;
  localparam logic [1:0] L2_LARGE = 2'b01;
  localparam logic [1:0] L2_SMALL = 2'b10;
  localparam logic [1:0] L2_FINE  = 2'b11;

  // TLB entry layouts, MSB first. TAG is the virtual page number of the
  // mapping size (VA bits above the page offset).
  typedef struct packed {
    logic [11:0] tag;      // va[31:20]
    logic [11:0] base;     // desc[31:20]
    logic [3:0]  dac_sel;  // desc[8:5]
    logic [1:0]  ap;       // desc[11:10]
    logic [1:0]  cb;       // desc[3:2]
  } section_entry_t;

  typedef struct packed {
    logic [19:0] tag;      // va[31:12]
    logic [19:0] base;     // desc[31:12]
    logic [3:0]  dac_sel;  // L1 domain
    logic [7:0]  ap;       // desc[11:4]
    logic [1:0]  cb;       // desc[3:2]
  } small_entry_t;

  typedef struct packed {
    logic [15:0] tag;      // va[31:16]
    logic [15:0] base;     // desc[31:16]
    logic [3:0]  dac_sel;  // L1 domain
    logic [7:0]  ap;       // desc[11:4]
    logic [1:0]  cb;       // desc[3:2]
  } large_entry_t;

  typedef struct packed {
    logic [21:0] tag;      // va[31:10]
    logic [21:0] base;     // desc[31:10]
    logic [3:0]  dac_sel;  // L1 domain
    logic [1:0]  ap;       // desc[5:4]
    logic [1:0]  cb;       // desc[3:2]
  } fine_entry_t;

  localparam int SECTION_TLB_WDT = $bits(section_entry_t);
  localparam int SPAGE_TLB_WDT   = $bits(small_entry_t);
  localparam int LPAGE_TLB_WDT   = $bits(large_entry_t);
  localparam int FPAGE_TLB_WDT   = $bits(fine_entry_t);

  // First-level descriptor address: table base [31:14] + section index.
  function automatic logic [31:0] l1_desc_addr(input logic [17:0] tbl_base,
                                               input logic [11:0] sec_idx);
    return {tbl_base, sec_idx, 2'b00};
  endfunction

  // Coarse second-level table: 1 KB aligned, 256 entries.
  function automatic logic [31:0] coarse_desc_addr(input logic [21:0] tbl_base,
                                                   input logic [7:0]  pg_idx);
    return {tbl_base, pg_idx, 2'b00};
  endfunction

  // Fine second-level table: 4 KB aligned, 1024 entries.
  function automatic logic [31:0] fine_desc_addr(input logic [19:0] tbl_base,
                                                 input logic [9:0]  pg_idx);
    return {tbl_base, pg_idx, 2'b00};
  endfunction

endpackage

// File: rtl/zap_tlb_walker_entry_pack.sv
// ---------------------------------------------------------------------------
// zap_tlb_entry_pack
//
// Purely combinational: builds the four TLB entry images from the most
// recently fetched descriptor and the latched virtual address. The walker
// FSM decides which (if any) of them is written.
//
// Ports:
//   i_desc     descriptor bits [31:2] (type bits are the FSM's business)
//   i_va       virtual address bits [31:10] (all tag bits ever needed)
//   i_l1_dom   domain latched from the first-level page-table descriptor
//   o_section  section TLB entry image
//   o_small    small page TLB entry image
//   o_large    large page TLB entry image
//   o_fine     fine page TLB entry image
// ---------------------------------------------------------------------------
module zap_tlb_entry_pack
  import zap_tlb_walker_pkg::*;
(
  input  logic [31:2]                i_desc,
  input  logic [31:10]               i_va,
  input  logic [3:0]                 i_l1_dom,
  output logic [SECTION_TLB_WDT-1:0] o_section,
  output logic [SPAGE_TLB_WDT-1:0]   o_small,
  output logic [LPAGE_TLB_WDT-1:0]   o_large,
  output logic [FPAGE_TLB_WDT-1:0]   o_fine
);

  section_entry_t sec;
  small_entry_t   spg;
  large_entry_t   lpg;
  fine_entry_t    fpg;

  always_comb begin
    // A section carries its own domain; page entries inherit the domain of
    // the first-level descriptor that pointed at their table.
    sec.tag     = i_va[31:20];
    sec.base    = i_desc[31:20];
    sec.dac_sel = i_desc[8:5];
    sec.ap      = i_desc[11:10];
    sec.cb      = i_desc[3:2];

    spg.tag     = i_va[31:12];
    spg.base    = i_desc[31:12];
    spg.dac_sel = i_l1_dom;
    spg.ap      = i_desc[11:4];
    spg.cb      = i_desc[3:2];

    lpg.tag     = i_va[31:16];
    lpg.base    = i_desc[31:16];
    lpg.dac_sel = i_l1_dom;
    lpg.ap      = i_desc[11:4];
    lpg.cb      = i_desc[3:2];

    fpg.tag     = i_va[31:10];
    fpg.base    = i_desc[31:10];
    fpg.dac_sel = i_l1_dom;
    fpg.ap      = i_desc[5:4];
    fpg.cb      = i_desc[3:2];
  end

  assign o_section = sec;
  assign o_small   = spg;
  assign o_large   = lpg;
  assign o_fine    = fpg;

endmodule

// File: rtl/zap_tlb_walker.sv
// ---------------------------------------------------------------------------
// zap_tlb_walker
//
// MMU page-table walker. On a TLB miss request it reads the first-level
// descriptor (and, for coarse/fine tables, the second-level descriptor) over
// a read-only Wishbone master, then issues exactly one TLB refill strobe or
// one fault report, followed by a one-cycle settle before accepting the next
// request. All outputs are registered.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_walk, i_va, i_baddr     walk request, virtual address, table base
//   o_busy                    high while not idle
//   o_wb_*, i_wb_*            Wishbone read master (cyc/stb/adr/sel/we,
//                             dat/ack/err)
//   o_*tlb_wen, o_*tlb_wdata  one-cycle refill strobes with entry data
//   o_fault, o_fsr, o_far     one-cycle fault pulse with status and VA
// ---------------------------------------------------------------------------
module zap_tlb_walker
  import zap_tlb_walker_pkg::*;
#(
  parameter int unsigned LPAGE_TLB_ENTRIES   = 8,
  parameter int unsigned SPAGE_TLB_ENTRIES   = 8,
  parameter int unsigned SECTION_TLB_ENTRIES = 8,
  parameter int unsigned FPAGE_TLB_ENTRIES   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_walk,
  input  logic [31:0]                i_va,
  input  logic [31:0]                i_baddr,
  output logic                       o_busy,
  output logic                       o_wb_cyc,
  output logic                       o_wb_stb,
  output logic [31:0]                o_wb_adr,
  output logic [3:0]                 o_wb_sel,
  output logic                       o_wb_we,
  input  logic [31:0]                i_wb_dat,
  input  logic                       i_wb_ack,
  input  logic                       i_wb_err,
  output logic                       o_setlb_wen,
  output logic                       o_sptlb_wen,
  output logic                       o_lptlb_wen,
  output logic                       o_fptlb_wen,
  output logic [SECTION_TLB_WDT-1:0] o_setlb_wdata,
  output logic [SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
  output logic [LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
  output logic [FPAGE_TLB_WDT-1:0]   o_fptlb_wdata,
  output logic                       o_fault,
  output logic [7:0]                 o_fsr,
  output logic [31:0]                o_far
);

  walk_state_t  state_q, state_d;
  refill_kind_t kind_q, kind_d;

  logic [31:0] va_q, va_d;
  logic [31:0] desc_q, desc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] far_q, far_d;
  logic [3:0]  dom_q, dom_d;
  logic        fine_q, fine_d;
  logic        cyc_q, cyc_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [7:0]  pend_fsr_q, pend_fsr_d;
  logic [7:0]  fsr_q, fsr_d;
  logic [3:0]  wen_q, wen_d;

  logic [SECTION_TLB_WDT-1:0] setlb_wdata_q, setlb_wdata_d;
  logic [SPAGE_TLB_WDT-1:0]   sptlb_wdata_q, sptlb_wdata_d;
  logic [LPAGE_TLB_WDT-1:0]   lptlb_wdata_q, lptlb_wdata_d;
  logic [FPAGE_TLB_WDT-1:0]   fptlb_wdata_q, fptlb_wdata_d;

  logic [SECTION_TLB_WDT-1:0] sec_img;
  logic [SPAGE_TLB_WDT-1:0]   spg_img;
  logic [LPAGE_TLB_WDT-1:0]   lpg_img;
  logic [FPAGE_TLB_WDT-1:0]   fpg_img;

  // Low table-base bits are implied zero by the 16 KB table alignment.
  logic unused_baddr_low;
  assign unused_baddr_low = ^i_baddr[13:0];

  // A configuration with a zero-depth TLB has nothing to refill; the entry
  // images are then tied off instead of packed.
  if ((LPAGE_TLB_ENTRIES > 0) && (SPAGE_TLB_ENTRIES > 0) &&
      (SECTION_TLB_ENTRIES > 0) && (FPAGE_TLB_ENTRIES > 0)) begin : g_pack
    zap_tlb_entry_pack u_pack (
      .i_desc    (desc_q[31:2]),
      .i_va      (va_q[31:10]),
      .i_l1_dom  (dom_q),
      .o_section (sec_img),
      .o_small   (spg_img),
      .o_large   (lpg_img),
      .o_fine    (fpg_img)
    );
  end else begin : g_no_pack
    assign sec_img = '0;
    assign spg_img = '0;
    assign lpg_img = '0;
    assign fpg_img = '0;
  end

  // State register. Reset clears the bus request immediately, so a walk in
  // flight is abandoned without a refill or fault pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      kind_q        <= RK_SECTION;
      va_q          <= '0;
      desc_q        <= '0;
      adr_q         <= '0;
      far_q         <= '0;
      dom_q         <= '0;
      fine_q        <= 1'b0;
      cyc_q         <= 1'b0;
      sel_q         <= '0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      pend_fsr_q    <= '0;
      fsr_q         <= '0;
      wen_q         <= '0;
      setlb_wdata_q <= '0;
      sptlb_wdata_q <= '0;
      lptlb_wdata_q <= '0;
      fptlb_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      va_q          <= va_d;
      desc_q        <= desc_d;
      adr_q         <= adr_d;
      far_q         <= far_d;
      dom_q         <= dom_d;
      fine_q        <= fine_d;
      cyc_q         <= cyc_d;
      sel_q         <= sel_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      pend_fsr_q    <= pend_fsr_d;
      fsr_q         <= fsr_d;
      wen_q         <= wen_d;
      setlb_wdata_q <= setlb_wdata_d;
      sptlb_wdata_q <= sptlb_wdata_d;
      lptlb_wdata_q <= lptlb_wdata_d;
      fptlb_wdata_q <= fptlb_wdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    va_d          = va_q;
    desc_d        = desc_q;
    adr_d         = adr_q;
    far_d         = far_q;
    dom_d         = dom_q;
    fine_d        = fine_q;
    cyc_d         = cyc_q;
    pend_fsr_d    = pend_fsr_q;
    fsr_d         = fsr_q;
    setlb_wdata_d = setlb_wdata_q;
    sptlb_wdata_d = sptlb_wdata_q;
    lptlb_wdata_d = lptlb_wdata_q;
    fptlb_wdata_d = fptlb_wdata_q;
    wen_d         = '0;
    fault_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_walk) begin
          va_d    = i_va;
          adr_d   = l1_desc_addr(i_baddr[31:14], i_va[31:20]);
          cyc_d   = 1'b1;
          dom_d   = '0;
          fine_d  = 1'b0;
          state_d = S_FETCH_L1;
        end
      end

      // err takes priority over a simultaneous ack.
      S_FETCH_L1: begin
        if (i_wb_err) begin
          cyc_d      = 1'b0;
          pend_fsr_d = {4'd0, FSR_EXT_ABORT_L1};
          state_d    = S_FAULT;
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          desc_d  = i_wb_dat;
          state_d = S_DECODE_L1;
        end
      end

      S_DECODE_L1: begin
        unique case (desc_q[1:0])
          L1_FAULT: begin
            pend_fsr_d = {4'd0, FSR_TRANS_SECTION};
            state_d    = S_FAULT;
          end
          L1_SECTION: begin
            kind_d  = RK_SECTION;
            state_d = S_REFILL;
          end
          L1_COARSE: begin
            dom_d   = desc_q[8:5];
            adr_d   = coarse_desc_addr(desc_q[31:10], va_q[19:12]);
            cyc_d   = 1'b1;
            state_d = S_FETCH_L2;
          end
          default: begin  // L1_FINE
            dom_d   = desc_q[8:5];
            adr_d   = fine_desc_addr(desc_q[31:12], va_q[19:10]);
            fine_d  = 1'b1;
            cyc_d   = 1'b1;
            state_d = S_FETCH_L2;
          end
        endcase
      end

      S_FETCH_L2: begin
        if (i_wb_err) begin
          cyc_d      = 1'b0;
          pend_fsr_d = {dom_q, FSR_EXT_ABORT_L2};
          state_d    = S_FAULT;
        end else if (i_wb_ack) begin
          cyc_d   = 1'b0;
          desc_d  = i_wb_dat;
          state_d = S_DECODE_L2;
        end
      end

      S_DECODE_L2: begin
        unique case (desc_q[1:0])
          L2_LARGE: begin
            kind_d  = RK_LARGE;
            state_d = S_REFILL;
          end
          L2_SMALL: begin
            kind_d  = RK_SMALL;
            state_d = S_REFILL;
          end
          L2_FINE: begin
            // Tiny/fine descriptors are only legal inside a fine table.
            if (fine_q) begin
              kind_d  = RK_FINE;
              state_d = S_REFILL;
            end else begin
              pend_fsr_d = {dom_q, FSR_TRANS_PAGE};
              state_d    = S_FAULT;
            end
          end
          default: begin  // L2_FAULT
            pend_fsr_d = {dom_q, FSR_TRANS_PAGE};
            state_d    = S_FAULT;
          end
        endcase
      end

      S_REFILL: begin
        wen_d[kind_q] = 1'b1;
        setlb_wdata_d = sec_img;
        sptlb_wdata_d = spg_img;
        lptlb_wdata_d = lpg_img;
        fptlb_wdata_d = fpg_img;
        state_d       = S_SETTLE;
      end

      S_FAULT: begin
        fault_d = 1'b1;
        fsr_d   = pend_fsr_q;
        far_d   = va_q;
        state_d = S_SETTLE;
      end

      // One dead cycle so the TLB read port reflects the new entry before
      // the check logic can raise another miss.
      S_SETTLE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    sel_d  = cyc_d ? 4'hF : 4'h0;
    busy_d = (state_d != S_IDLE);
  end

  assign o_busy        = busy_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = cyc_q;
  assign o_wb_adr      = adr_q;
  assign o_wb_sel      = sel_q;
  assign o_wb_we       = 1'b0;
  assign o_setlb_wen   = wen_q[RK_SECTION];
  assign o_sptlb_wen   = wen_q[RK_SMALL];
  assign o_lptlb_wen   = wen_q[RK_LARGE];
  assign o_fptlb_wen   = wen_q[RK_FINE];
  assign o_setlb_wdata = setlb_wdata_q;
  assign o_sptlb_wdata = sptlb_wdata_q;
  assign o_lptlb_wdata = lptlb_wdata_q;
  assign o_fptlb_wdata = fptlb_wdata_q;
  assign o_fault       = fault_q;
  assign o_fsr         = fsr_q;
  assign o_far         = far_q;

endmodule

// File: tb/tb_zap_tlb_walker.sv
// ---------------------------------------------------------------------------
// tb_zap_tlb_walker
//
// Directed, table-driven bench for the page-table walker. A small Wishbone
// slave returns a first-level then a second-level descriptor, with optional
// wait states, bus errors and ack+err collisions. Each walk reports the
// refill/fault it produced, its latency, and the descriptor addresses read.
// ---------------------------------------------------------------------------
module tb_zap_tlb_walker;
  import zap_tlb_walker_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_walk;
  logic [31:0] i_va;
  logic [31:0] i_baddr;
  logic        o_busy, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack, i_wb_err;
  logic        o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen;
  logic [SECTION_TLB_WDT-1:0] o_setlb_wdata;
  logic [SPAGE_TLB_WDT-1:0]   o_sptlb_wdata;
  logic [LPAGE_TLB_WDT-1:0]   o_lptlb_wdata;
  logic [FPAGE_TLB_WDT-1:0]   o_fptlb_wdata;
  logic        o_fault;
  logic [7:0]  o_fsr;
  logic [31:0] o_far;

  always #5 clk = ~clk;

  zap_tlb_walker #(
    .LPAGE_TLB_ENTRIES   (8),
    .SPAGE_TLB_ENTRIES   (8),
    .SECTION_TLB_ENTRIES (8),
    .FPAGE_TLB_ENTRIES   (8)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_walk        (i_walk),
    .i_va          (i_va),
    .i_baddr       (i_baddr),
    .o_busy        (o_busy),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .o_wb_adr      (o_wb_adr),
    .o_wb_sel      (o_wb_sel),
    .o_wb_we       (o_wb_we),
    .i_wb_dat      (i_wb_dat),
    .i_wb_ack      (i_wb_ack),
    .i_wb_err      (i_wb_err),
    .o_setlb_wen   (o_setlb_wen),
    .o_sptlb_wen   (o_sptlb_wen),
    .o_lptlb_wen   (o_lptlb_wen),
    .o_fptlb_wen   (o_fptlb_wen),
    .o_setlb_wdata (o_setlb_wdata),
    .o_sptlb_wdata (o_sptlb_wdata),
    .o_lptlb_wdata (o_lptlb_wdata),
    .o_fptlb_wdata (o_fptlb_wdata),
    .o_fault       (o_fault),
    .o_fsr         (o_fsr),
    .o_far         (o_far)
  );

  // ---------------- Wishbone slave model ----------------
  logic [31:0] l1_data = '0;
  logic [31:0] l2_data = '0;
  int          err_at = 0;       // 0 none, 1 error on L1 read, 2 on L2 read
  logic        err_with_ack = 1'b0;
  logic        stall_l2 = 1'b0;
  int          wait_n = 0;
  int          rd_idx = 0;
  int          wcnt = 0;
  logic        ready;

  always_comb begin
    ready    = 1'b0;
    i_wb_err = 1'b0;
    i_wb_ack = 1'b0;
    ready    = o_wb_cyc && o_wb_stb && (wcnt >= wait_n) && !(stall_l2 && rd_idx == 1);
    i_wb_err = ready && (err_at == rd_idx + 1);
    i_wb_ack = ready && (!i_wb_err || err_with_ack);
    i_wb_dat = (rd_idx == 0) ? l1_data : l2_data;
  end

  always @(posedge clk) begin
    if (!o_busy) rd_idx <= 0;
    else if (i_wb_ack || i_wb_err) rd_idx <= rd_idx + 1;
    if (!o_wb_cyc || i_wb_ack || i_wb_err) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Per-walk observations (event kinds: 0 section, 1 small, 2 large, 3 fine, 4 fault)
  int          ev_total, first_kind, lat, n_rd;
  logic [31:0] adr1, adr2, cur_adr, cap_far;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_fsr;
  logic        proto_bad, timed_out;

  task automatic note(input int k, input logic [63:0] w, input int i);
    ev_total++;
    if (ev_total == 1) begin
      first_kind = k;
      lat        = i;
      cap_wdata  = w;
    end
  endtask

  task automatic run_walk(input logic [31:0] va, input logic [31:0] baddr);
    logic prev_cyc;
    logic done;
    ev_total = 0; first_kind = -1; lat = -1; n_rd = 0;
    adr1 = '0; adr2 = '0; cur_adr = '0; cap_far = '0; cap_wdata = '0; cap_fsr = '0;
    proto_bad = 1'b0;
    prev_cyc = 1'b0;
    done = 1'b0;
    @(negedge clk);
    i_walk = 1'b1; i_va = va; i_baddr = baddr;
    for (int i = 1; i <= 80 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin
        i_walk = 1'b0;
        i_va   = ~va;   // must not leak into the walk
      end
      if (o_wb_cyc && !prev_cyc) begin
        n_rd++;
        if (n_rd == 1) adr1 = o_wb_adr;
        else if (n_rd == 2) adr2 = o_wb_adr;
        cur_adr = o_wb_adr;
      end else if (o_wb_cyc && o_wb_adr != cur_adr) begin
        proto_bad = 1'b1;
      end
      if (o_wb_stb != o_wb_cyc || o_wb_we || o_wb_sel != (o_wb_cyc ? 4'hF : 4'h0))
        proto_bad = 1'b1;
      if (o_setlb_wen) note(0, 64'(o_setlb_wdata), i);
      if (o_sptlb_wen) note(1, 64'(o_sptlb_wdata), i);
      if (o_lptlb_wen) note(2, 64'(o_lptlb_wdata), i);
      if (o_fptlb_wen) note(3, 64'(o_fptlb_wdata), i);
      if (o_fault) begin
        note(4, 64'(0), i);
        cap_fsr = o_fsr;
        cap_far = o_far;
      end
      if (ev_total > 0 && !o_busy) done = 1'b1;
      prev_cyc = o_wb_cyc;
    end
    timed_out = !done;
  endtask

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] baddr;
    logic [31:0] l1;
    logic [31:0] l2;
    int          err_at;
    logic        err_with_ack;
    int          wait_n;
    int          exp_kind;
    int          exp_reads;
    logic [31:0] exp_adr1;
    logic [31:0] exp_adr2;
    int          exp_lat;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_fsr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic found;
    logic stray;

    vecs[0] = '{"section", 32'h1230_0ABC, 32'h0000_4000, 32'h8000_0C1E, 32'h0, 0, 1'b0, 0,
                0, 1, 32'h0000_448C, 32'h0, 4,
                64'({12'h123, 12'h800, 4'h0, 2'b11, 2'b11}), 8'h00};
    vecs[1] = '{"small", 32'h0000_5123, 32'h0000_4000, 32'h0010_0021, 32'h9000_0FFE, 0, 1'b0, 0,
                1, 2, 32'h0000_4000, 32'h0010_0014, 6,
                64'({20'h00005, 20'h90000, 4'h1, 8'hFF, 2'b11}), 8'h00};
    vecs[2] = '{"l1_fault", 32'hDEAD_BEEF, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b0, 0,
                4, 1, 32'h0000_B7A8, 32'h0, 4, 64'h0, 8'h05};
    vecs[3] = '{"coarse_l2_11", 32'h0003_4567, 32'h0000_4000, 32'h0020_00A1, 32'h1234_5673, 0, 1'b0, 0,
                4, 2, 32'h0000_4000, 32'h0020_00D0, 6, 64'h0, 8'h57};
    vecs[4] = '{"fine", 32'h0000_ABCD, 32'h0000_4000, 32'h0030_0043, 32'hCAFE_1C3B, 0, 1'b0, 0,
                3, 2, 32'h0000_4000, 32'h0030_00A8, 6,
                64'({22'h00002A, 22'h32BF87, 4'h2, 2'b11, 2'b10}), 8'h00};
    vecs[5] = '{"l2_buserr", 32'h0000_1000, 32'h0000_4000, 32'h0040_0061, 32'h0, 2, 1'b0, 0,
                4, 2, 32'h0000_4000, 32'h0040_0004, 5, 64'h0, 8'h3E};
    vecs[6] = '{"large", 32'h0007_F000, 32'hFFFF_C000, 32'h0050_0001, 32'hABCD_5A35, 0, 1'b0, 0,
                2, 2, 32'hFFFF_C000, 32'h0050_01FC, 6,
                64'({16'h0007, 16'hABCD, 4'h0, 8'hA3, 2'b01}), 8'h00};
    vecs[7] = '{"l1_err_ack", 32'h1111_2222, 32'h0000_4000, 32'h8000_0C1E, 32'h0, 1, 1'b1, 0,
                4, 1, 32'h0000_4444, 32'h0, 3, 64'h0, 8'h0C};
    vecs[8] = '{"section_wait3", 32'h1230_0ABC, 32'h0000_4000, 32'h8000_0C1E, 32'h0, 0, 1'b0, 3,
                0, 1, 32'h0000_448C, 32'h0, 7,
                64'({12'h123, 12'h800, 4'h0, 2'b11, 2'b11}), 8'h00};

    // ---------------- reset state ----------------
    i_reset = 1'b1; i_walk = 1'b0; i_va = '0; i_baddr = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(o_busy), 64'(0));
    chk("rst.cyc_stb", 64'({o_wb_cyc, o_wb_stb}), 64'(0));
    chk("rst.adr_sel", 64'({o_wb_adr, o_wb_sel}), 64'(0));
    chk("rst.wen", 64'({o_setlb_wen, o_sptlb_wen, o_lptlb_wen, o_fptlb_wen}), 64'(0));
    chk("rst.fault", 64'({o_fault, o_fsr, o_far}), 64'(0));
    chk("rst.wdata", 64'(o_sptlb_wdata), 64'(0));
    i_reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", 64'(o_busy), 64'(0));

    // ---------------- table-driven walks ----------------
    for (int v = 0; v < 9; v++) begin
      l1_data      = vecs[v].l1;
      l2_data      = vecs[v].l2;
      err_at       = vecs[v].err_at;
      err_with_ack = vecs[v].err_with_ack;
      wait_n       = vecs[v].wait_n;
      stall_l2     = 1'b0;
      run_walk(vecs[v].va, vecs[v].baddr);
      $display("[TB] walk %s va=%08h kind=%0d lat=%0d reads=%0d adr1=%08h adr2=%08h fsr=%02h",
               vecs[v].name, vecs[v].va, first_kind, lat, n_rd, adr1, adr2, cap_fsr);
      chk({vecs[v].name, ".timeout"}, 64'(timed_out), 64'(0));
      chk({vecs[v].name, ".events"}, 64'(ev_total), 64'(1));
      chk({vecs[v].name, ".kind"}, 64'(first_kind), 64'(vecs[v].exp_kind));
      chk({vecs[v].name, ".latency"}, 64'(lat), 64'(vecs[v].exp_lat));
      chk({vecs[v].name, ".reads"}, 64'(n_rd), 64'(vecs[v].exp_reads));
      chk({vecs[v].name, ".adr1"}, 64'(adr1), 64'(vecs[v].exp_adr1));
      if (vecs[v].exp_reads == 2)
        chk({vecs[v].name, ".adr2"}, 64'(adr2), 64'(vecs[v].exp_adr2));
      if (vecs[v].exp_kind == 4) begin
        chk({vecs[v].name, ".fsr"}, 64'(cap_fsr), 64'(vecs[v].exp_fsr));
        chk({vecs[v].name, ".far"}, 64'(cap_far), 64'(vecs[v].va));
      end else begin
        chk({vecs[v].name, ".wdata"}, cap_wdata, vecs[v].exp_wdata);
      end
      chk({vecs[v].name, ".bus_protocol"}, 64'(proto_bad), 64'(0));
    end

    // ---------------- reset while waiting for the L2 ack ----------------
    l1_data = 32'h0010_0021; l2_data = 32'h9000_0FFE;
    err_at = 0; err_with_ack = 1'b0; wait_n = 0; stall_l2 = 1'b1;
    @(negedge clk);
    i_walk = 1'b1; i_va = 32'h0000_5123; i_baddr = 32'h0000_4000;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      i_walk = 1'b0;
      if (o_wb_cyc && rd_idx == 1) found = 1'b1;
    end
    chk("rstmid.reached_l2", 64'(found), 64'(1));
    chk("rstmid.l2_adr", 64'(o_wb_adr), 64'(32'h0010_0014));
    #2 i_reset = 1'b1;
    #1;
    chk("rstmid.cyc_stb_async", 64'({o_wb_cyc, o_wb_stb}), 64'(0));
    chk("rstmid.busy_async", 64'(o_busy), 64'(0));
    @(negedge clk);
    i_reset  = 1'b0;
    stall_l2 = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_setlb_wen || o_sptlb_wen || o_lptlb_wen || o_fptlb_wen || o_fault ||
          o_wb_cyc || o_busy)
        stray = 1'b1;
    end
    $display("[TB] walk reset_mid_l2 va=00005123 abandoned stray=%0d", stray);
    chk("rstmid.no_strobes", 64'(stray), 64'(0));

    // ---------------- walk after reset recovers ----------------
    l1_data = vecs[0].l1; err_at = 0; wait_n = 0;
    run_walk(vecs[0].va, vecs[0].baddr);
    $display("[TB] walk post_reset_section va=%08h kind=%0d lat=%0d", vecs[0].va, first_kind, lat);
    chk("post_reset.kind", 64'(first_kind), 64'(0));
    chk("post_reset.latency", 64'(lat), 64'(4));
    chk("post_reset.wdata", cap_wdata, vecs[0].exp_wdata);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
